stfq_rank_computer: RTL and testbench
=====================================

Name: stfq_rank_computer

Overview:
- Upstream stage of the PIFO flow scheduler.
- Tags up to two arriving packets per cycle with a Start-Time Fair Queueing rank: rank = max(vtime, last_finish[flow]).
- Emits the tagged packets on the scheduler's two push lanes and honours the scheduler's can_push_1/can_push_2 back-pressure.
- Tracks per-flow finish tags and per-flow weights, and advances virtual time from dequeue reports on the egress path.

Parameters:
- FLOWS, 10, number of flows; flow ids are one-hot [FLOWS-1:0].
- LEN_W, 16, packet length width in bytes.
- WT_W, 8, per-flow weight (inverse share) width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid_1  in  1  lane-1 arrival
- in_value_1  in  32  lane-1 payload handle
- in_flow_1  in  FLOWS  lane-1 one-hot flow
- in_len_1  in  LEN_W  lane-1 length
- in_valid_2, in_value_2, in_flow_2, in_len_2: same as lane 1, for lane 2
- in_ready  out  1  both lanes accepted when high
- push_1  out  1  to scheduler push_1
- push_rank_1  out  32  to scheduler
- push_value_1  out  32  to scheduler
- push_flow_1  out  FLOWS  to scheduler
- push_2, push_rank_2, push_value_2, push_flow_2: same as lane 1, to the scheduler's lane 2
- can_push_1  in  1  from scheduler
- can_push_2  in  1  from scheduler
- deq_valid  in  1  egress dequeue report
- deq_rank  in  32  rank of dequeued packet
- cfg_we  in  1  weight write
- cfg_flow  in  $clog2(FLOWS)  binary flow index
- cfg_weight  in  WT_W  new weight
- err_flow  out  1  one-cycle pulse: non-one-hot flow dropped

Behaviour:
- Reset (sync, rst=1):
  - vtime=0, all last_finish=0, all weights=1.
  - Stage register empty; push_1=push_2=0, err_flow=0, in_ready=0 during reset, 1 the cycle after.
- Stage register: one entry per lane (sv1/sv2 plus rank, value, flow).
- Fire rule:
  - fire = (sv1&&sv2&&can_push_2) || (sv1^sv2 && can_push_1).
  - push_1=sv1&&fire, push_2=sv2&&fire, carrying the stage contents.
  - Lanes are never split: a pair waits for can_push_2.
- Ready: in_ready = !(sv1||sv2) || fire. The arrival handshake for lane k is in_valid_k && in_ready.
- Latency: exactly 1 cycle from accepted arrival to push when downstream is not back-pressuring.
- Tag computation on accept, combinational from registered state:
  - Lane 1: s1 = max(vtime, last_finish[f1]); fin1 = s1 + in_len_1*weight[f1].
  - Lane 2 on the same flow as lane 1: s2 = max(vtime, fin1).
  - Lane 2 otherwise: s2 = max(vtime, last_finish[f2]).
  - fin2 = s2 + in_len_2*weight[f2].
  - last_finish[f] <= fin of the later lane on f.
- Arithmetic:
  - Product len*weight is LEN_W+WT_W bits, zero-extended to 32.
  - All 32-bit sums wrap modulo 2^32 with no saturation.
  - Comparisons are unsigned.
- Only valid lanes update state. A lane-2-only arrival is placed in the lane-1 output slot (compaction), so a single packet always uses push_1.
- Invalid flow (zero or multi-hot):
  - The lane is consumed and dropped; no state update, no push.
  - err_flow pulses the cycle after acceptance.
  - The other lane is processed normally.
- Virtual time:
  - On deq_valid, vtime <= max(vtime, deq_rank); vtime is monotonic.
  - Arrivals in the same cycle use the old vtime.
- Config:
  - cfg_we writes weight[cfg_flow] and takes effect next cycle.
  - An arrival in the same cycle on that flow uses the old weight.
  - cfg_flow >= FLOWS is ignored.
  - Weight 0 is legal: finish = start.
- Reset mid-operation: staged packets are discarded and never pushed; the tables clear.

Test Plan:
- Single packet flow 0 (0b1), len 100, weight 1, vtime 0 -> push_1=1 next cycle, rank 0; a second flow-0 packet, len 50, gets rank 100.
- Pair on the same flow 2, lens 10 and 20, weight[2]=3 -> push_1 rank 0, push_2 rank 30; last_finish[2]=90 (a later packet ranks 90).
- deq_valid with deq_rank=500, then a flow-1 packet with last_finish 40 -> rank 500; deq_rank=200 afterwards leaves vtime 500.
- Pair staged with can_push_2=0, can_push_1=1 -> push held, in_ready=0; can_push_2 rises -> both pushed that cycle and in_ready=1.
- Lane-1 flow=0 (zero), lane-2 flow 0b100, len 8 -> err_flow pulses, push_1=1 carrying the lane-2 packet, push_2=0.
- cfg write weight[3]=4 in the same cycle as a flow-3 len-10 arrival -> finish uses weight 1 (next flow-3 rank 10); the following arrival uses 4.

Source files
------------

// File: rtl/stfq_rank_computer.sv
// Start-Time Fair Queueing rank tagger in front of the PIFO scheduler.
// Tags up to two arrivals per cycle and forwards them on the scheduler push lanes.
module stfq_rank_computer #(
    parameter int FLOWS = 10,
    parameter int LEN_W = 16,
    parameter int WT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid_1,
    input  logic [31:0]              in_value_1,
    input  logic [FLOWS-1:0]         in_flow_1,
    input  logic [LEN_W-1:0]         in_len_1,
    input  logic                     in_valid_2,
    input  logic [31:0]              in_value_2,
    input  logic [FLOWS-1:0]         in_flow_2,
    input  logic [LEN_W-1:0]         in_len_2,
    output logic                     in_ready,
    output logic                     push_1,
    output logic [31:0]              push_rank_1,
    output logic [31:0]              push_value_1,
    output logic [FLOWS-1:0]         push_flow_1,
    output logic                     push_2,
    output logic [31:0]              push_rank_2,
    output logic [31:0]              push_value_2,
    output logic [FLOWS-1:0]         push_flow_2,
    input  logic                     can_push_1,
    input  logic                     can_push_2,
    input  logic                     deq_valid,
    input  logic [31:0]              deq_rank,
    input  logic                     cfg_we,
    input  logic [$clog2(FLOWS)-1:0] cfg_flow,
    input  logic [WT_W-1:0]          cfg_weight,
    output logic                     err_flow
);
    localparam int IDX_W = $clog2(FLOWS);
    localparam int P_W   = LEN_W + WT_W;

    logic [31:0]      vtime;
    logic [31:0]      last_finish [FLOWS];
    logic [WT_W-1:0]  weight [FLOWS];

    logic             sv1, sv2, err_q;
    logic [31:0]      sr1, sr2, sval1, sval2;
    logic [FLOWS-1:0] sf1, sf2;

    logic             fire, accept, ok1, ok2, take1, take2;
    logic [IDX_W-1:0] idx1, idx2;
    logic [P_W-1:0]   prod1, prod2;
    logic [31:0]      s1, fin1, s2, fin2, base2;

    function automatic logic is_onehot(input logic [FLOWS-1:0] f);
        return (f != '0) && ((f & (f - 1'b1)) == '0);
    endfunction

    function automatic logic [IDX_W-1:0] to_index(input logic [FLOWS-1:0] f);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < FLOWS; i++)
            if (f[i]) r = IDX_W'(i);
        return r;
    endfunction

    assign fire     = (sv1 && sv2 && can_push_2) || ((sv1 ^ sv2) && can_push_1);
    assign accept   = !rst && (!(sv1 || sv2) || fire);
    assign in_ready = accept;

    assign ok1   = is_onehot(in_flow_1);
    assign ok2   = is_onehot(in_flow_2);
    assign take1 = in_valid_1 && accept && ok1;
    assign take2 = in_valid_2 && accept && ok2;
    assign idx1  = to_index(in_flow_1);
    assign idx2  = to_index(in_flow_2);

    // Lane 2 on the same flow as a valid lane 1 starts after lane 1's finish.
    always_comb begin
        prod1 = P_W'(in_len_1) * P_W'(weight[idx1]);
        prod2 = P_W'(in_len_2) * P_W'(weight[idx2]);
        s1    = (last_finish[idx1] > vtime) ? last_finish[idx1] : vtime;
        fin1  = s1 + {{(32-P_W){1'b0}}, prod1};
        base2 = (take1 && (in_flow_1 == in_flow_2)) ? fin1 : last_finish[idx2];
        s2    = (base2 > vtime) ? base2 : vtime;
        fin2  = s2 + {{(32-P_W){1'b0}}, prod2};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vtime <= '0;
            for (int i = 0; i < FLOWS; i++) begin
                last_finish[i] <= '0;
                weight[i]      <= WT_W'(1);
            end
            sv1   <= 1'b0;
            sv2   <= 1'b0;
            err_q <= 1'b0;
            sr1   <= '0;
            sr2   <= '0;
            sval1 <= '0;
            sval2 <= '0;
            sf1   <= '0;
            sf2   <= '0;
        end else begin
            if (deq_valid && (deq_rank > vtime))
                vtime <= deq_rank;
            if (cfg_we && (32'(cfg_flow) < 32'(FLOWS)))
                weight[cfg_flow] <= cfg_weight;
            if (take1)
                last_finish[idx1] <= fin1;
            if (take2)
                last_finish[idx2] <= fin2;
            err_q <= (in_valid_1 && accept && !ok1) || (in_valid_2 && accept && !ok2);
            if (accept) begin
                sv1 <= take1 || take2;
                sv2 <= take1 && take2;
                // A lone lane-2 packet is compacted into slot 1.
                if (take1) begin
                    sr1   <= s1;
                    sval1 <= in_value_1;
                    sf1   <= in_flow_1;
                end else begin
                    sr1   <= s2;
                    sval1 <= in_value_2;
                    sf1   <= in_flow_2;
                end
                sr2   <= s2;
                sval2 <= in_value_2;
                sf2   <= in_flow_2;
            end
        end
    end

    assign push_1       = sv1 && fire && !rst;
    assign push_2       = sv2 && fire && !rst;
    assign push_rank_1  = sr1;
    assign push_value_1 = sval1;
    assign push_flow_1  = sf1;
    assign push_rank_2  = sr2;
    assign push_value_2 = sval2;
    assign push_flow_2  = sf2;
    assign err_flow     = err_q && !rst;
endmodule

// File: tb/tb_stfq_rank_computer.sv
// Bench for stfq_rank_computer: directed scenarios with literal ranks, then
// randomized traffic checked every cycle against a packet-level STFQ model.
module tb_stfq_rank_computer;
    localparam int FLOWS = 10;
    localparam int LEN_W = 16;
    localparam int WT_W  = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid_1, in_valid_2;
    logic [31:0]      in_value_1, in_value_2;
    logic [FLOWS-1:0] in_flow_1, in_flow_2;
    logic [LEN_W-1:0] in_len_1, in_len_2;
    logic             in_ready;
    logic             push_1, push_2;
    logic [31:0]      push_rank_1, push_value_1, push_rank_2, push_value_2;
    logic [FLOWS-1:0] push_flow_1, push_flow_2;
    logic             can_push_1, can_push_2;
    logic             deq_valid;
    logic [31:0]      deq_rank;
    logic             cfg_we;
    logic [3:0]       cfg_flow;
    logic [WT_W-1:0]  cfg_weight;
    logic             err_flow;

    int checks = 0;
    int errors = 0;

    stfq_rank_computer #(.FLOWS(FLOWS), .LEN_W(LEN_W), .WT_W(WT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid_1(in_valid_1), .in_value_1(in_value_1), .in_flow_1(in_flow_1), .in_len_1(in_len_1),
        .in_valid_2(in_valid_2), .in_value_2(in_value_2), .in_flow_2(in_flow_2), .in_len_2(in_len_2),
        .in_ready(in_ready),
        .push_1(push_1), .push_rank_1(push_rank_1), .push_value_1(push_value_1), .push_flow_1(push_flow_1),
        .push_2(push_2), .push_rank_2(push_rank_2), .push_value_2(push_value_2), .push_flow_2(push_flow_2),
        .can_push_1(can_push_1), .can_push_2(can_push_2),
        .deq_valid(deq_valid), .deq_rank(deq_rank),
        .cfg_we(cfg_we), .cfg_flow(cfg_flow), .cfg_weight(cfg_weight),
        .err_flow(err_flow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      rank;
        logic [31:0]      value;
        logic [FLOWS-1:0] flow;
    } ent_t;

    logic [31:0]     m_vt;
    logic [31:0]     m_lf [FLOWS];
    logic [WT_W-1:0] m_wt [FLOWS];
    ent_t            m_pend [$];
    logic            m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_vt = 0;
        for (int i = 0; i < FLOWS; i++) begin
            m_lf[i] = 0;
            m_wt[i] = 1;
        end
        m_pend.delete();
        m_err = 0;
    endtask

    // Lanes are handled in order, so a same-flow lane 2 sees lane 1's finish.
    task automatic model_lane(input logic v, input logic [FLOWS-1:0] f,
                              input logic [LEN_W-1:0] len, input logic [31:0] val);
        int idx;
        logic [31:0] s;
        ent_t e;
        if (!v) return;
        if ($countones(f) != 1) begin
            m_err = 1;
            return;
        end
        idx = 0;
        for (int i = 0; i < FLOWS; i++) if (f[i]) idx = i;
        s = (m_lf[idx] > m_vt) ? m_lf[idx] : m_vt;
        m_lf[idx] = s + 32'(len) * 32'(m_wt[idx]);
        e.rank = s;
        e.value = val;
        e.flow = f;
        m_pend.push_back(e);
    endtask

    // One clock: compare at the falling edge, advance the model, land 1 after the rising edge.
    task automatic step();
        int n;
        logic fire, rdy;
        @(negedge clk);
        n = m_pend.size();
        fire = !rst && ((n == 2 && can_push_2) || (n == 1 && can_push_1));
        rdy  = !rst && (n == 0 || fire);
        chk("in_ready", 32'(in_ready), 32'(rdy));
        chk("push_1", 32'(push_1), 32'(fire && n >= 1));
        chk("push_2", 32'(push_2), 32'(fire && n == 2));
        chk("err_flow", 32'(err_flow), 32'(!rst && m_err));
        if (fire) begin
            chk("rank_1", push_rank_1, m_pend[0].rank);
            chk("value_1", push_value_1, m_pend[0].value);
            chk("flow_1", 32'(push_flow_1), 32'(m_pend[0].flow));
            if (n == 2) begin
                chk("rank_2", push_rank_2, m_pend[1].rank);
                chk("value_2", push_value_2, m_pend[1].value);
                chk("flow_2", 32'(push_flow_2), 32'(m_pend[1].flow));
            end
        end
        if (rst) begin
            model_reset();
        end else begin
            if (fire) m_pend.delete();
            m_err = 0;
            if (rdy) begin
                model_lane(in_valid_1, in_flow_1, in_len_1, in_value_1);
                model_lane(in_valid_2, in_flow_2, in_len_2, in_value_2);
            end
            if (deq_valid && deq_rank > m_vt) m_vt = deq_rank;
            if (cfg_we && cfg_flow < FLOWS) m_wt[cfg_flow] = cfg_weight;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid_1 = 0; in_value_1 = 0; in_flow_1 = 0; in_len_1 = 0;
        in_valid_2 = 0; in_value_2 = 0; in_flow_2 = 0; in_len_2 = 0;
        deq_valid = 0; deq_rank = 0;
        cfg_we = 0; cfg_flow = 0; cfg_weight = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        step();
        rst = 0;
        #1;
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);
        chk("post_reset_push_1", 32'(push_1), 32'd0);
    endtask

    task automatic lane1(input logic [FLOWS-1:0] f, input logic [LEN_W-1:0] len, input logic [31:0] val);
        in_valid_1 = 1; in_flow_1 = f; in_len_1 = len; in_value_1 = val;
    endtask

    task automatic lane2(input logic [FLOWS-1:0] f, input logic [LEN_W-1:0] len, input logic [31:0] val);
        in_valid_2 = 1; in_flow_2 = f; in_len_2 = len; in_value_2 = val;
    endtask

    initial begin
        rst = 1; can_push_1 = 1; can_push_2 = 1;
        idle();
        model_reset();
        do_reset();

        // Single packets on flow 0.
        lane1(10'b1, 100, 32'hA001); step();
        chk("t1_push", 32'(push_1), 32'd1);
        chk("t1_rank_a", push_rank_1, 32'd0);
        idle(); lane1(10'b1, 50, 32'hA002); step();
        chk("t1_rank_b", push_rank_1, 32'd100);
        idle(); step();

        // Same-flow pair with weight 3.
        do_reset();
        cfg_we = 1; cfg_flow = 2; cfg_weight = 3; step();
        idle(); lane1(10'b100, 10, 32'hB001); lane2(10'b100, 20, 32'hB002); step();
        chk("t2_rank_1", push_rank_1, 32'd0);
        chk("t2_push_2", 32'(push_2), 32'd1);
        chk("t2_rank_2", push_rank_2, 32'd30);
        idle(); lane1(10'b100, 1, 32'hB003); step();
        chk("t2_rank_3", push_rank_1, 32'd90);
        idle(); step();

        // Virtual time advance and monotonicity.
        do_reset();
        lane1(10'b10, 40, 32'hC001); step();
        idle(); deq_valid = 1; deq_rank = 500; step();
        idle(); lane1(10'b10, 5, 32'hC002); step();
        chk("t3_rank_vt", push_rank_1, 32'd500);
        idle(); deq_valid = 1; deq_rank = 200; step();
        idle(); lane1(10'b100000, 7, 32'hC003); step();
        chk("t3_vt_mono", push_rank_1, 32'd500);
        idle(); step();

        // Pair held by can_push_2.
        do_reset();
        can_push_2 = 0;
        lane1(10'b1, 3, 32'hD001); lane2(10'b10, 4, 32'hD002); step();
        idle(); #1;
        chk("t4_held_push", 32'(push_1), 32'd0);
        chk("t4_held_ready", 32'(in_ready), 32'd0);
        step();
        can_push_2 = 1; #1;
        chk("t4_rel_push_1", 32'(push_1), 32'd1);
        chk("t4_rel_push_2", 32'(push_2), 32'd1);
        chk("t4_rel_ready", 32'(in_ready), 32'd1);
        step();

        // Invalid lane-1 flow, lane 2 compacted into slot 1.
        do_reset();
        lane1(10'b0, 9, 32'hE001); lane2(10'b100, 8, 32'hE002); step();
        chk("t5_err", 32'(err_flow), 32'd1);
        chk("t5_push_1", 32'(push_1), 32'd1);
        chk("t5_value", push_value_1, 32'hE002);
        chk("t5_flow", 32'(push_flow_1), 32'(10'b100));
        chk("t5_push_2", 32'(push_2), 32'd0);
        idle(); step();

        // Weight write concurrent with an arrival uses the old weight.
        do_reset();
        cfg_we = 1; cfg_flow = 3; cfg_weight = 4; lane1(10'b1000, 10, 32'hF001); step();
        idle(); lane1(10'b1000, 10, 32'hF002); step();
        chk("t6_old_weight", push_rank_1, 32'd10);
        idle(); lane1(10'b1000, 10, 32'hF003); step();
        chk("t6_new_weight", push_rank_1, 32'd50);
        idle(); step();

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            int r;
            idle();
            rst = ($urandom_range(0, 299) == 0);
            can_push_1 = ($urandom_range(0, 9) < 7);
            can_push_2 = ($urandom_range(0, 9) < 6);
            for (int k = 0; k < 2; k++) begin
                logic [FLOWS-1:0] f;
                r = $urandom_range(0, 15);
                if (r == 0) f = '0;
                else if (r == 1) f = FLOWS'($urandom);
                else f = FLOWS'(1) << $urandom_range(0, FLOWS - 1);
                if (k == 0) begin
                    in_valid_1 = $urandom_range(0, 1);
                    in_flow_1 = f; in_len_1 = LEN_W'($urandom_range(0, 3000)); in_value_1 = $urandom;
                end else begin
                    in_valid_2 = $urandom_range(0, 1);
                    in_flow_2 = ($urandom_range(0, 3) == 0) ? in_flow_1 : f;
                    in_len_2 = ($urandom_range(0, 19) == 0) ? LEN_W'($urandom) : LEN_W'($urandom_range(0, 3000));
                    in_value_2 = $urandom;
                end
            end
            if ($urandom_range(0, 9) == 0) begin
                deq_valid = 1;
                deq_rank = ($urandom_range(0, 49) == 0) ? 32'($urandom) : m_vt + 32'($urandom_range(0, 4000)) - 32'd1000;
            end
            if ($urandom_range(0, 9) == 0) begin
                cfg_we = 1;
                cfg_flow = 4'($urandom_range(0, 15));
                cfg_weight = WT_W'($urandom_range(0, 255));
            end
            step();
        end
        rst = 0;
        idle();
        can_push_1 = 1; can_push_2 = 1;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
